av_pixel_mixer: RTL

AV_PIXEL_MIXER -- requirements
Module: av_pixel_mixer

---
 rtl/av_pixel_mixer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/av_pixel_mixer.sv
// Two-stage pixel mixer: blends a menu overlay onto the game layer with a
// frame-stepped fade (alpha 0..8) driven by the pause request.
module av_pixel_mixer #(
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input  logic        clk65,
  input  logic        reset,
  input  logic        pause,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [12:0] menu_pixel,
  input  logic [11:0] game_pixel,
  output logic [11:0] vga_rgb,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  alpha,
  output logic        menu_visible
);

  typedef enum logic [1:0] {StHidden, StFadeIn, StShown, StFadeOut} state_e;

  localparam logic [3:0] StepCount = 4'(FRAMES_PER_STEP);

  // Stage 1 registers
  logic [11:0] game_q, menu_q;
  logic        blank_q, hsync_q, vsync_q;
  // Stage 2 (output) registers
  logic [11:0] rgb_q;
  logic        hsync2_q, vsync2_q;

  state_e      state_q, state_d;
  logic [3:0]  alpha_q, alpha_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        vis_q;
  logic        frame_tick, step_tick;
  logic [11:0] rgb_d;

  // Debug-only inputs and the ignored menu flag bit.
  logic unused_inputs;
  assign unused_inputs = ^{hcount, vcount, menu_pixel[12]};

  function automatic logic [3:0] mix(input logic [3:0] m, input logic [3:0] g,
                                     input logic [3:0] a);
    logic [6:0] s;
    s = ({3'b0, m} * {3'b0, a}) + ({3'b0, g} * (7'd8 - {3'b0, a}));
    return s[6:3];
  endfunction

  // Registered vsync falling: stage-1 copy low while stage-2 copy still high.
  assign frame_tick = vsync2_q & ~vsync_q;
  assign step_tick  = frame_tick && ((cnt_q + 4'd1) == StepCount);

  // Stage-2 colour: blanking wins, then menu coverage, else game passes through.
  always_comb begin
    rgb_d = game_q;
    if (blank_q) begin
      rgb_d = 12'h000;
    end else if (menu_q != 12'h000) begin
      rgb_d = {mix(menu_q[11:8], game_q[11:8], alpha_q),
               mix(menu_q[7:4],  game_q[7:4],  alpha_q),
               mix(menu_q[3:0],  game_q[3:0],  alpha_q)};
    end
  end

  // Pixel pipeline registers.
  always_ff @(posedge clk65) begin
    if (reset) begin
      game_q   <= 12'h000;
      menu_q   <= 12'h000;
      blank_q  <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      rgb_q    <= 12'h000;
      hsync2_q <= 1'b1;
      vsync2_q <= 1'b1;
    end else begin
      game_q   <= game_pixel;
      menu_q   <= menu_pixel[11:0];
      blank_q  <= blank;
      hsync_q  <= hsync;
      vsync_q  <= vsync;
      rgb_q    <= rgb_d;
      hsync2_q <= hsync_q;
      vsync2_q <= vsync_q;
    end
  end

  // Fade FSM: a pause change beats a coincident step and clears the divider.
  always_comb begin
    state_d = state_q;
    alpha_d = alpha_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StHidden: begin
        if (pause) begin
          state_d = StFadeIn;
          cnt_d   = 4'd0;
        end
      end
      StFadeIn: begin
        if (!pause) begin
          state_d = StFadeOut;
          cnt_d   = 4'd0;
        end else if (step_tick) begin
          cnt_d = 4'd0;
          if (alpha_q < 4'd8) alpha_d = alpha_q + 4'd1;
          if (alpha_q >= 4'd7) state_d = StShown;
        end else if (frame_tick) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StShown: begin
        if (!pause) begin
          state_d = StFadeOut;
          cnt_d   = 4'd0;
        end
      end
      StFadeOut: begin
        if (pause) begin
          state_d = StFadeIn;
          cnt_d   = 4'd0;
        end else if (step_tick) begin
          cnt_d = 4'd0;
          if (alpha_q > 4'd0) alpha_d = alpha_q - 4'd1;
          if (alpha_q <= 4'd1) state_d = StHidden;
        end else if (frame_tick) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StHidden;
        alpha_d = 4'd0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Fade state, alpha, divider and visibility flag.
  always_ff @(posedge clk65) begin
    if (reset) begin
      state_q <= StHidden;
      alpha_q <= 4'd0;
      cnt_q   <= 4'd0;
      vis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      cnt_q   <= cnt_d;
      vis_q   <= (alpha_d != 4'd0);
    end
  end

  assign vga_rgb      = rgb_q;
  assign vga_hsync    = hsync2_q;
  assign vga_vsync    = vsync2_q;
  assign alpha        = alpha_q;
  assign menu_visible = vis_q;

endmodule
